pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter HOLD_CYCLES, default 2, range 1..15, SHALL be the number of post-reset cycles before the first fetch request.
REQ-003 Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Stall  input  1  SHALL be the hazard-unit stall; 1 freezes PC advance.
REQ-006 Redirect  input  1  SHALL be a one-cycle branch/jump-taken strobe.
REQ-007 RedirectAddr  input  32  SHALL be the branch/jump target, valid when Redirect=1.
REQ-008 ReqReady  input  1  SHALL be instruction-memory acceptance of the current request.
REQ-009 ReqValid  output  1  SHALL be the fetch request valid.
REQ-010 ReqAddr  output  32  SHALL be the fetch address, always equal to PC.
REQ-011 PCPlus4  output  32  SHALL be PC+4, modulo 2^32.
REQ-012 FetchValid  output  1  SHALL be a one-cycle pulse marking a completed, non-squashed fetch.
REQ-013 FetchPC  output  32  SHALL be the address of the fetch flagged by FetchValid.
REQ-014 AlignErr  output  1  SHALL be a one-cycle pulse flagging a misaligned RedirectAddr.

Function
REQ-015 The FSM SHALL have states HOLD, REQ and STALLED; HOLD SHALL be entered only from reset.
REQ-016 In HOLD, ReqValid SHALL be 0 and a 4-bit counter SHALL increment each cycle; after HOLD_CYCLES cycles the FSM SHALL enter REQ, or STALLED if Stall=1.
REQ-017 In REQ, ReqValid SHALL be 1; when Stall=1 and no request is pending acceptance, the FSM SHALL enter STALLED with ReqValid=0 the next cycle.
REQ-018 A handshake SHALL occur when ReqValid=1 and ReqReady=1 in the same cycle; on a handshake PC SHALL load the next address on the following edge.
REQ-019 The next address SHALL be, in priority order: RedirectAddr (Redirect=1 this cycle), the pending target (pending valid), or PCPlus4.
REQ-020 While ReqValid=1 and ReqReady=0, PC and ReqAddr SHALL remain stable, and ReqValid SHALL stay 1 even if Stall rises.
REQ-021 A Redirect that arrives without a same-cycle handshake (STALLED, HOLD, or request waiting) SHALL be stored in a one-entry pending buffer; a newer Redirect SHALL overwrite an older pending one.
REQ-022 In STALLED, a pending target SHALL be loaded into PC on the edge where Stall falls to 0 and the FSM returns to REQ; the pending buffer SHALL then clear.
REQ-023 In HOLD, a pending target SHALL be loaded into PC on the HOLD exit edge.
REQ-024 FetchValid SHALL pulse 1 for one cycle, with FetchPC equal to the handshaken address, exactly one cycle after each handshake.
REQ-025 FetchValid SHALL be suppressed (squashed) for a handshake that coincides with Redirect=1.
REQ-026 RedirectAddr[1:0] SHALL be forced to 2'b00 before use; AlignErr SHALL pulse the cycle after Redirect if RedirectAddr[1:0] is nonzero.
REQ-027 PC+4 SHALL wrap: 32'hFFFF_FFFC advances to 32'h0000_0000 with no error indication.

Reset
REQ-028 On Rst=0, asynchronously: PC=RESET_VECTOR, PCPlus4=RESET_VECTOR+4, ReqValid=0, FetchValid=0, FetchPC=0, AlignErr=0, pending buffer cleared, counter=0, FSM=HOLD.
REQ-029 Reset asserted mid-request or mid-stall SHALL discard the outstanding request and pending target with no FetchValid emitted.

Verification
REQ-030 Reset release, HOLD_CYCLES=2, ReqReady=1, Stall=0 -> ReqValid rises on cycle 3; ReqAddr sequence 0,4,8; FetchValid pulses with FetchPC 0,4,8.
REQ-031 ReqReady=0 for 3 cycles at PC=0x10 with Stall pulsed -> ReqAddr held at 0x10, ReqValid held 1, no FetchValid until ReqReady=1.
REQ-032 Stall=1 at PC=0x20, Redirect to 0x100 during the stall, then Stall=0 -> ReqAddr=0x100 on resume; 0x24 is never requested.
REQ-033 Redirect to 0x203 coincident with a handshake at 0x40 -> no FetchValid for 0x40; next ReqAddr=0x200; AlignErr pulses once.
REQ-034 PC=0xFFFF_FFFC, handshake with no Redirect -> next ReqAddr=0x0000_0000 and PCPlus4=0x0000_0004.
REQ-035 Rst=0 asserted while a Redirect is pending in STALLED -> outputs reach REQ-028 values immediately, without waiting for a clock edge; after release, the first ReqAddr is RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: post-reset hold, request/stall FSM,
// a one-entry pending redirect buffer and squash-aware fetch completion.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned HOLD_CYCLES  = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddr,
    input  logic        ReqReady,
    output logic        ReqValid,
    output logic [31:0] ReqAddr,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic [31:0] FetchPC,
    output logic        AlignErr
);

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        align_err_q, align_err_d;

    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic [31:0] resume_tgt;
    logic        handshake;

    assign redir_tgt  = {RedirectAddr[31:2], 2'b00};
    assign pc_plus4   = pc_q + 32'd4;
    assign handshake  = ReqValid && ReqReady;
    // A redirect seen on the resume edge itself is newer than anything buffered.
    assign resume_tgt = Redirect ? redir_tgt : (pend_valid_q ? pend_addr_q : pc_q);

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        align_err_d   = Redirect && (RedirectAddr[1:0] != 2'b00);

        // Capture by default; the branches below consume the buffer when PC moves.
        if (Redirect) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = redir_tgt;
        end

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 4'd1;
                if (hold_cnt_q == HOLD_LAST) begin
                    pc_d         = resume_tgt;
                    pend_valid_d = 1'b0;
                    state_d      = Stall ? ST_STALLED : ST_REQ;
                end
            end
            ST_REQ: begin
                if (handshake) begin
                    if (Redirect)
                        pc_d = redir_tgt;
                    else if (pend_valid_q)
                        pc_d = pend_addr_q;
                    else
                        pc_d = pc_plus4;
                    pend_valid_d  = 1'b0;
                    fetch_valid_d = !Redirect;
                    fetch_pc_d    = pc_q;
                    if (Stall)
                        state_d = ST_STALLED;
                end
            end
            ST_STALLED: begin
                if (!Stall) begin
                    pc_d         = resume_tgt;
                    pend_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= 4'd0;
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= 32'd0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'd0;
            align_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            align_err_q   <= align_err_d;
        end
    end

    assign ReqValid   = (state_q == ST_REQ);
    assign ReqAddr    = pc_q;
    assign PCPlus4    = pc_plus4;
    assign FetchValid = fetch_valid_q;
    assign FetchPC    = fetch_pc_q;
    assign AlignErr   = align_err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, reset-during-stall sequence,
// and randomized traffic against a queue-based reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int unsigned HC = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectAddr = 32'd0;
    logic        ReqReady = 1'b0;
    logic        ReqValid;
    logic [31:0] ReqAddr;
    logic [31:0] PCPlus4;
    logic        FetchValid;
    logic [31:0] FetchPC;
    logic        AlignErr;

    pc_fetch_ctrl #(.RESET_VECTOR(RV), .HOLD_CYCLES(HC)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect),
        .RedirectAddr(RedirectAddr), .ReqReady(ReqReady), .ReqValid(ReqValid),
        .ReqAddr(ReqAddr), .PCPlus4(PCPlus4), .FetchValid(FetchValid),
        .FetchPC(FetchPC), .AlignErr(AlignErr)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rv, input logic [31:0] addr,
                              input logic fv, input logic [31:0] fpc, input logic ae);
        check({tag, " ReqValid"}, {31'd0, ReqValid}, {31'd0, rv});
        check({tag, " ReqAddr"}, ReqAddr, addr);
        check({tag, " PCPlus4"}, PCPlus4, addr + 32'd4);
        check({tag, " FetchValid"}, {31'd0, FetchValid}, {31'd0, fv});
        check({tag, " AlignErr"}, {31'd0, AlignErr}, {31'd0, ae});
        if (fv)
            check({tag, " FetchPC"}, FetchPC, fpc);
    endtask

    // Reference model: PC, remaining hold cycles, paused flag, pending-target queue.
    logic [31:0] m_pc;
    int          m_hold_left;
    bit          m_paused;
    logic [31:0] m_pend[$];
    logic        m_fv;
    logic [31:0] m_fpc;
    logic        m_ae;

    task automatic model_reset();
        m_pc = RV;
        m_hold_left = HC;
        m_paused = 1'b0;
        m_pend.delete();
        m_fv = 1'b0;
        m_fpc = 32'd0;
        m_ae = 1'b0;
    endtask

    function automatic logic model_rv();
        return (m_hold_left == 0) && !m_paused;
    endfunction

    task automatic model_step(input logic st, input logic rd, input logic [31:0] ra, input logic rr);
        logic [31:0] ra_al;
        ra_al = ra & 32'hFFFF_FFFC;
        m_ae = rd && (ra[1:0] != 2'b00);
        m_fv = 1'b0;
        if (model_rv() && rr) begin
            m_fv = !rd;
            m_fpc = m_pc;
            if (rd) m_pc = ra_al;
            else if (m_pend.size() > 0) m_pc = m_pend[0];
            else m_pc = m_pc + 32'd4;
            m_pend.delete();
            m_paused = st;
        end else begin
            if (rd) begin
                m_pend.delete();
                m_pend.push_back(ra_al);
            end
            if (m_hold_left > 0) begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    if (m_pend.size() > 0) m_pc = m_pend.pop_front();
                    m_paused = st;
                end
            end else if (m_paused && !st) begin
                if (m_pend.size() > 0) m_pc = m_pend.pop_front();
                m_paused = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic        stall;
        logic        rd;
        logic [31:0] ra;
        logic        rr;
        logic        rv;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] fpc;
        logic        ae;
    } vec_t;

    vec_t vecs[$];
    bit   do_rst;

    initial begin
        // stall, redirect, raddr, ready | ReqValid, ReqAddr, FetchValid, FetchPC, AlignErr
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 32'h4,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b1, 32'h8,         1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        1'b1, 32'hC,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14,        1'b1, 32'h10,        1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h18,        1'b1, 32'h14,        1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1C,        1'b1, 32'h18,        1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h20,        1'b1, 32'h1C,        1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h100,       1'b1, 1'b0, 32'h20,        1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h20,        1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h20,        1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h40,        1'b1, 1'b1, 32'h104,       1'b1, 32'h100,       1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h203,       1'b1, 1'b1, 32'h40,        1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h200,       1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0});

        // Reset state
        Rst = 1'b0;
        #1;
        check_outs("reset", 1'b0, RV, 1'b0, 32'd0, 1'b0);
        check("reset FetchPC", FetchPC, 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            Stall = vecs[i].stall;
            Redirect = vecs[i].rd;
            RedirectAddr = vecs[i].ra;
            ReqReady = vecs[i].rr;
            @(negedge Clk);
            $display("vec %0d: ReqValid=%0b ReqAddr=%h FetchValid=%0b FetchPC=%h AlignErr=%0b",
                     i, ReqValid, ReqAddr, FetchValid, FetchPC, AlignErr);
            check_outs($sformatf("vec%0d", i), vecs[i].rv, vecs[i].addr, vecs[i].fv, vecs[i].fpc, vecs[i].ae);
            @(posedge Clk);
            #1;
        end

        // Reset while a redirect is pending in the stalled state
        Stall = 1'b1; Redirect = 1'b0; ReqReady = 1'b1;
        @(posedge Clk); #1;
        Redirect = 1'b1; RedirectAddr = 32'h301;
        @(posedge Clk); #1;
        Redirect = 1'b0;
        #2;
        Rst = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, RV, 1'b0, 32'd0, 1'b0);
        check("async_rst FetchPC", FetchPC, 32'd0);
        $display("async reset: ReqValid=%0b ReqAddr=%h AlignErr=%0b", ReqValid, ReqAddr, AlignErr);
        @(posedge Clk);
        @(posedge Clk); #1;
        Rst = 1'b1; Stall = 1'b0; ReqReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            $display("post-reset cycle %0d: ReqValid=%0b ReqAddr=%h FetchValid=%0b", c, ReqValid, ReqAddr, FetchValid);
            if (c < 2)       check_outs($sformatf("post_rst%0d", c), 1'b0, RV, 1'b0, 32'd0, 1'b0);
            else if (c == 2) check_outs("post_rst2", 1'b1, RV, 1'b0, 32'd0, 1'b0);
            else             check_outs("post_rst3", 1'b1, RV + 32'd4, 1'b1, RV, 1'b0);
            @(posedge Clk); #1;
        end

        // Randomized traffic against the reference model
        Rst = 1'b0;
        model_reset();
        @(posedge Clk); #1;
        Rst = 1'b1;
        for (int i = 0; i < 800; i++) begin
            do_rst = ($urandom_range(0, 149) == 0);
            Stall = ($urandom_range(0, 3) == 0);
            Redirect = ($urandom_range(0, 7) == 0);
            RedirectAddr = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : $urandom();
            ReqReady = ($urandom_range(0, 3) != 0);
            if (do_rst) begin
                Rst = 1'b0;
                model_reset();
            end
            @(negedge Clk);
            if (FetchValid)
                $display("rand %0d: fetch pc=%h", i, FetchPC);
            check_outs($sformatf("rand%0d", i), model_rv(), m_pc, m_fv, m_fpc, m_ae);
            @(posedge Clk);
            if (!do_rst)
                model_step(Stall, Redirect, RedirectAddr, ReqReady);
            #1;
            Rst = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
